// File: rtl/sram_stream_adapter.sv
// Valid/ready request front end for a 1-cycle-latency SRAM with an in-order response FIFO.
// Optional SRAM_ADAPTER_WR_ACK_EN: writes also return an acknowledge response.
module sram_stream_adapter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RESP_DEPTH = 2,
  localparam int unsigned AW = $clog2(NUM_WORDS),
  localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  resp_we_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

`ifdef SRAM_ADAPTER_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  we;
  } resp_t;

  logic            acc;
  logic            in_rng;
  logic            rp;
  logic            push;
  logic            pop;
  logic            infl_q;
  logic            infl_err_q;
  logic            infl_we_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  resp_t           fifo_q [RESP_DEPTH];
  resp_t           push_data;
  resp_t           head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request side: accept, range check, and whether the op owes a response
  always_comb begin
    in_rng       = 32'(req_addr_i) < NUM_WORDS;
    rp           = ~req_we_i | WR_ACK;
    pop          = resp_valid_o & resp_ready_i;
    req_ready_o  = ((32'(cnt_q) + 32'(infl_q)) < RESP_DEPTH) | pop;
    acc          = req_valid_i & req_ready_o;
    sram_req_o   = acc & in_rng;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
  end

  // One-deep in-flight tracker aligned with the SRAM read latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_q     <= 1'b0;
      infl_err_q <= 1'b0;
      infl_we_q  <= 1'b0;
    end else begin
      infl_q     <= acc & rp;
      infl_err_q <= ~in_rng;
      infl_we_q  <= req_we_i;
    end
  end

  always_comb begin
    push            = infl_q;
    push_data.rdata = (infl_err_q | infl_we_q) ? '0 : sram_rdata_i;
    push_data.err   = infl_err_q;
    push_data.we    = WR_ACK & infl_we_q;
  end

  // Response storage; contents need no reset because the head is gated by cnt
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    head         = fifo_q[rd_ptr_q];
    resp_valid_o = (cnt_q != '0);
    resp_rdata_o = resp_valid_o ? head.rdata : '0;
    resp_err_o   = resp_valid_o & head.err;
    resp_we_o    = resp_valid_o & head.we;
  end

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Directed bench for sram_stream_adapter with an SRAM model and a response scoreboard.
// Expectations follow SRAM_ADAPTER_WR_ACK_EN when it is defined for the build.
module tb_sram_stream_adapter;

  localparam int unsigned NW = 1000;

`ifdef SRAM_ADAPTER_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [9:0]  req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_be_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_rdata_o;
  logic        resp_err_o;
  logic        resp_we_o;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [9:0]  sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [7:0]  sram_be_o;
  logic [63:0] sram_rdata_i;

  sram_stream_adapter #(.DATA_WIDTH(64), .NUM_WORDS(NW), .RESP_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .resp_we_o(resp_we_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        we;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] sram_mem [1024];
  logic [63:0] ref_mem  [1024];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sram_cnt = 0;
  int          resp_count = 0;
  int          stalls = 0;
  bit          lat_check = 1'b0;
  logic [63:0] last_rdata = '0;
  logic        mon_acc;
  logic        mon_inr;

  function automatic logic [63:0] pre(input int i);
    return {16'hC0DE, 16'(i), 32'h1357_9BDF ^ 32'(i * 40503)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: 1-cycle read latency, byte-enabled writes, reloaded while in reset
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= pre(i);
    end else if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  // Monitor: scoreboard push on accept, pop/compare on response handshake
  always @(negedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = pre(i);
    end else begin
      mon_acc = req_valid_i && req_ready_o;
      mon_inr = 32'(req_addr_i) < NW;
      check("sram_strobe", 64'(sram_req_o), 64'(mon_acc && mon_inr));
      if (sram_req_o) sram_cnt++;
      if (resp_valid_o && resp_ready_i) begin
        resp_count++;
        last_rdata = resp_rdata_o;
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid_o), 64'(0));
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata_o, e.rdata);
          check("resp_err", 64'(resp_err_o), 64'(e.err));
          check("resp_we", 64'(resp_we_o), 64'(e.we));
          if (lat_check) check("latency", 64'(cyc - e.cyc), 64'(2));
        end
      end
      if (mon_acc) begin
        if (!req_we_i || WR_ACK) begin
          e.rdata = (!req_we_i && mon_inr) ? ref_mem[req_addr_i] : 64'h0;
          e.err   = !mon_inr;
          e.we    = req_we_i;
          e.cyc   = cyc;
          sb.push_back(e);
        end
        if (req_we_i && mon_inr)
          for (int b = 0; b < 8; b++)
            if (req_be_i[b]) ref_mem[req_addr_i][8*b +: 8] = req_wdata_i[8*b +: 8];
      end
    end
  end

  task automatic issue(input logic we, input int addr, input logic [63:0] wd, input logic [7:0] be);
    int n;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = 10'(addr);
    req_wdata_i = wd;
    req_be_i    = be;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("accept_timeout", 64'(req_ready_o), 64'(1));
    stalls += n;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    resp_ready_i = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'(sb.size()), 64'(0));
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0;
    int r0;
    rst_ni       = 1'b0;
    resp_ready_i = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_be_i     = '0;
    #2;
    check("rst_valid", 64'(resp_valid_o), 64'(0));
    check("rst_rdata", resp_rdata_o, 64'h0);
    check("rst_err", 64'(resp_err_o), 64'(0));
    check("rst_we", 64'(resp_we_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(req_ready_o), 64'(1));
    @(posedge clk);
    #1;

    // Write then read back at address 5
    lat_check = 1'b1;
    s0 = sram_cnt;
    issue(1'b1, 5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    issue(1'b0, 5, 64'h0, 8'h00);
    drain();
    check("t1_strobes", 64'(sram_cnt - s0), 64'(2));
    check("t1_rdata", last_rdata, 64'hDEAD_BEEF_0123_4567);

    // Back-to-back reads of preloaded words
    stalls = 0;
    r0 = resp_count;
    for (int i = 0; i < 8; i++) issue(1'b0, i, 64'h0, 8'h00);
    check("b2b_stalls", 64'(stalls), 64'(0));
    drain();
    check("b2b_count", 64'(resp_count - r0), 64'(8));
    check("b2b_last", last_rdata, pre(7));
    lat_check = 1'b0;

    // Backpressure: only two reads fit, the third goes in the pop cycle
    r0 = resp_count;
    resp_ready_i = 1'b0;
    issue(1'b0, 10, 64'h0, 8'h00);
    issue(1'b0, 11, 64'h0, 8'h00);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 10'd12;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(req_ready_o), 64'(0));
      @(posedge clk);
      #1;
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_pop_valid", 64'(resp_valid_o), 64'(1));
    check("bp_pop_ready", 64'(req_ready_o), 64'(1));
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    issue(1'b0, 13, 64'h0, 8'h00);
    drain();
    check("bp_count", 64'(resp_count - r0), 64'(4));
    check("bp_last", last_rdata, pre(13));

    // Out-of-range read and write around a valid read
    s0 = sram_cnt;
    r0 = resp_count;
    issue(1'b0, 1000, 64'h0, 8'h00);
    issue(1'b1, 1023, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    issue(1'b0, 3, 64'h0, 8'h00);
    drain();
    check("rng_strobes", 64'(sram_cnt - s0), 64'(1));
    check("rng_count", 64'(resp_count - r0), WR_ACK ? 64'(3) : 64'(2));
    check("rng_last", last_rdata, pre(3));

    // Write acknowledge behaviour and partial byte enables
    r0 = resp_count;
    issue(1'b1, 2, 64'h1122_3344_5566_7788, 8'hFF);
    issue(1'b0, 2, 64'h0, 8'h00);
    drain();
    check("wack_count", 64'(resp_count - r0), WR_ACK ? 64'(2) : 64'(1));
    check("wack_rdata", last_rdata, 64'h1122_3344_5566_7788);
    issue(1'b1, 6, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    issue(1'b0, 6, 64'h0, 8'h00);
    drain();
    s0 = 32'(pre(6) >> 32);
    check("be_rdata", last_rdata, {32'(s0), 32'hCCCC_DDDD});

    // Reset with one response queued and one read in flight
    resp_ready_i = 1'b0;
    issue(1'b0, 20, 64'h0, 8'h00);
    issue(1'b0, 21, 64'h0, 8'h00);
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", 64'(resp_valid_o), 64'(0));
    check("mid_rst_rdata", resp_rdata_o, 64'h0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    resp_ready_i = 1'b1;
    r0 = resp_count;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready_o), 64'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(resp_valid_o), 64'(0));
    end
    check("post_rst_count", 64'(resp_count - r0), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
